// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: function codes, widths and FSM states.
package alu_mc_pkg;

  localparam int ISA_WIDTH      = 32;
  localparam int ALU_FUNC_WIDTH = 5;
  localparam int ALU_FUNC_MAX   = 17;

  localparam logic [ALU_FUNC_WIDTH-1:0] F_ADD    = 5'd0;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_ADD_U  = 5'd1;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_SUB    = 5'd2;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_SUB_U  = 5'd3;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_NOT    = 5'd4;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_AND    = 5'd5;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_OR     = 5'd6;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_XOR    = 5'd7;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_EQ     = 5'd8;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_LESS_U = 5'd9;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_LESS_S = 5'd10;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_SLL    = 5'd11;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_SRL    = 5'd12;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_SRA    = 5'd13;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_MUL    = 5'd14;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_MULHU  = 5'd15;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_DIVU   = 5'd16;
  localparam logic [ALU_FUNC_WIDTH-1:0] F_REMU   = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_mul_div_iter.sv
// Shared iterative datapath: shift-add multiplier and restoring divider, one step per cycle.
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [WIDTH-1:0] lo_reg, hi_reg, opnd_reg;
  logic             div_reg;
  logic [WIDTH-1:0] lo_step, hi_step;
  logic [WIDTH:0]   shifted, sum;

  always_comb begin
    shifted = {hi_reg, lo_reg[WIDTH-1]};
    sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    if (div_reg) begin
      // A true difference always fits in WIDTH bits; a zero divisor degenerates to quotient all-ones, remainder a.
      if (shifted >= {1'b0, opnd_reg}) begin
        hi_step = shifted[WIDTH-1:0] - opnd_reg;
        lo_step = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = shifted[WIDTH-1:0];
        lo_step = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_step = sum[WIDTH:1];
      lo_step = {sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  // Look-ahead outputs let the FSM capture the finished value on the edge of the last step.
  assign lo = step ? lo_step : lo_reg;
  assign hi = step ? hi_step : hi_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_reg   <= '0;
      hi_reg   <= '0;
      opnd_reg <= '0;
      div_reg  <= 1'b0;
    end else if (start) begin
      lo_reg   <= is_div ? a : b;
      hi_reg   <= '0;
      opnd_reg <= is_div ? b : a;
      div_reg  <= is_div;
    end else if (step) begin
      lo_reg <= lo_step;
      hi_reg <= hi_step;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops finish in one cycle, mul/div in WIDTH+1.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH      = ISA_WIDTH,
  parameter int FUNC_WIDTH = ALU_FUNC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      alu_a,
  input  logic [WIDTH-1:0]      alu_b,
  input  logic [FUNC_WIDTH-1:0] alu_func,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      alu_result,
  output logic                  alu_zero
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  logic [SHW-1:0]   count;
  logic             sel_hi;
  logic [WIDTH-1:0] single_res, iter_res, lo, hi;
  logic [SHW-1:0]   sh;
  logic             is_mul, is_div, is_iter, accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign sh        = alu_b[SHW-1:0];

  assign is_mul  = (alu_func == FUNC_WIDTH'(F_MUL))  || (alu_func == FUNC_WIDTH'(F_MULHU));
  assign is_div  = (alu_func == FUNC_WIDTH'(F_DIVU)) || (alu_func == FUNC_WIDTH'(F_REMU));
  assign is_iter = is_mul || is_div;

  always_comb begin
    single_res = '0;
    case (alu_func)
      FUNC_WIDTH'(F_ADD), FUNC_WIDTH'(F_ADD_U): single_res = alu_a + alu_b;
      FUNC_WIDTH'(F_SUB), FUNC_WIDTH'(F_SUB_U): single_res = alu_a - alu_b;
      FUNC_WIDTH'(F_NOT):    single_res = ~alu_a;
      FUNC_WIDTH'(F_AND):    single_res = alu_a & alu_b;
      FUNC_WIDTH'(F_OR):     single_res = alu_a | alu_b;
      FUNC_WIDTH'(F_XOR):    single_res = alu_a ^ alu_b;
      FUNC_WIDTH'(F_EQ):     single_res = {{(WIDTH-1){1'b0}}, alu_a == alu_b};
      FUNC_WIDTH'(F_LESS_U): single_res = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
      FUNC_WIDTH'(F_LESS_S): single_res = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      FUNC_WIDTH'(F_SLL):    single_res = alu_a << sh;
      FUNC_WIDTH'(F_SRL):    single_res = alu_a >> sh;
      FUNC_WIDTH'(F_SRA):    single_res = WIDTH'($signed(alu_a) >>> sh);
      default:               single_res = '0;
    endcase
  end

  mul_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_iter),
    .is_div (is_div),
    .step   (state == BUSY),
    .a      (alu_a),
    .b      (alu_b),
    .lo     (lo),
    .hi     (hi)
  );

  // MULHU and REMU live in the upper half, MUL and DIVU in the lower half.
  assign iter_res = sel_hi ? hi : lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      sel_hi     <= 1'b0;
      alu_result <= '0;
      alu_zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_iter) begin
              state  <= BUSY;
              count  <= '0;
              sel_hi <= (alu_func == FUNC_WIDTH'(F_MULHU)) || (alu_func == FUNC_WIDTH'(F_REMU));
            end else begin
              state      <= DONE;
              alu_result <= single_res;
              alu_zero   <= (single_res == '0);
            end
          end
        end
        BUSY: begin
          if (count == SHW'(WIDTH-1)) begin
            state      <= DONE;
            count      <= '0;
            alu_result <= iter_res;
            alu_zero   <= (iter_res == '0);
          end else begin
            count <= count + SHW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised ALU that replaces the single-cycle combinational ALU in the NPC execute stage. Single-cycle functions (add/sub, logic, compares, shifts) complete one cycle after acceptance. Iterative functions (multiply, unsigned divide/remainder) run on a shared shift-add / restoring datapath for `WIDTH` cycles. Operands enter and results leave through valid/ready handshakes, so the control path can stall on long operations.

## Interface
- `WIDTH`, default `` `ISA_WIDTH ``: operand and result width, ≥ 2.
- `FUNC_WIDTH`, default `` `ALU_FUNC_WIDTH ``: function-code width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and function present.
- `in_ready`  out  1  block can accept; equals (state == IDLE).
- `alu_a`, `alu_b`  in  WIDTH  operands; sampled only on accept.
- `alu_func`  in  FUNC_WIDTH  function code; sampled only on accept.
- `out_valid`  out  1  `alu_result` / `alu_zero` are valid.
- `out_ready`  in  1  consumer takes the result.
- `alu_result`  out  WIDTH  registered result.
- `alu_zero`  out  1  registered: `alu_result == 0`.

## Operation
- Accept: `in_valid && in_ready`. The block latches `alu_a`, `alu_b` and `alu_func`; it ignores inputs at all other times.
- Single-cycle functions:
  - ADD, ADD_U: a+b mod 2^WIDTH.
  - SUB, SUB_U: a−b mod 2^WIDTH.
  - NOT: ~a. AND, OR, XOR: bitwise.
  - EQ: {0…, a==b}.
  - LESS_U: {0…, a<b unsigned}. LESS_S: {0…, a<b signed}.
  - SLL, SRL, SRA: a shifted by b[$clog2(WIDTH)-1:0]; upper bits of b ignored.
- Undefined function code: result 0, single-cycle path.
- Iterative functions:
  - MUL: low WIDTH bits of a*b.
  - MULHU: high WIDTH bits of the unsigned product.
  - DIVU: a/b unsigned. REMU: a%b unsigned.
- Divide by zero: DIVU returns all-ones; REMU returns a. No exception; same latency as a normal divide.
- State machine:
  - IDLE: `in_ready`=1. On accept, single-cycle function → DONE with the result registered. On accept, iterative function → BUSY with counter=0 and the datapath loaded.
  - BUSY: one multiply or divide step per cycle, counter+1. After step WIDTH−1 (counter==WIDTH−1) → DONE with the result registered.
  - DONE: `out_valid`=1; `alu_result` and `alu_zero` are held stable. If `out_ready` → IDLE; otherwise stay in DONE.
- Reset at any point, including mid-BUSY: the current operation is abandoned; state=IDLE, counter=0.
- Reset values of outputs: `in_ready`=1, `out_valid`=0, `alu_result`=0, `alu_zero`=1.

## Timing
- Latency is counted from the accept edge to the first cycle with `out_valid` high.
- Single-cycle functions: latency 1.
- Iterative functions: latency WIDTH+1.
- Result persistence: `alu_result` changes only on entry to DONE or on reset. It holds through any length of `out_ready` back-pressure.
- Throughput with `out_ready` tied high:
  - Single-cycle functions: one result per 2 cycles. The next accept can happen in the cycle after the DONE→IDLE edge.
  - Iterative functions: one result per WIDTH+2 cycles.
- `in_valid` asserted during BUSY/DONE: not accepted, because `in_ready`=0. The producer must hold its request.
- `out_ready` without `out_valid`: no effect.
- Simultaneous `rst` and accept: `rst` wins and nothing is latched.

## Structure
- The existing shared `config.v` gains new function codes: LESS_S, SLL, SRL, SRA, MUL, MULHU, DIVU, REMU.
- `ALU_FUNC_MAX` increases to match. `ALU_FUNC_WIDTH` widens if the new codes need more bits.
- State encodings (IDLE, BUSY, DONE) and the macro ALU_ITER_FUNC(f), which classifies iterative codes, also live in `config.v`.
- Single-cycle result selection reuses `MuxKeyWithDefault` and `adder_suber` with `data_len=WIDTH`.
- One sub-module, `mul_div_iter`:
  - Implements the 2·WIDTH-bit shift-add multiplier and the restoring divider.
  - Ports: start, is_div, step, a, b; outputs lo and hi.
  - Owns the product/remainder registers. `alu_mc` owns the FSM, the counter and the output registers.

## Test plan
All scenarios use WIDTH=32.
- Reset and ADD: assert `rst` for 2 cycles, then ADD a=0x7FFFFFFF, b=1 → `out_valid` 1 cycle after accept; result 0x80000000, `alu_zero`=0; before that, the reset values hold.
- Single-cycle functions: SUB a=5, b=5 → result 0, `alu_zero`=1. LESS_S a=0xFFFFFFFF, b=1 → 1. LESS_U with the same operands → 0. SRA a=0x80000000, b=0x21 → 0xC0000000.
- Multiply: MUL and MULHU with a=b=0xFFFFFFFF → 0x00000001 and 0xFFFFFFFE. `out_valid` rises exactly 33 cycles after accept; `in_ready`=0 throughout.
- Divide: DIVU 100/7 → 14; REMU 100/7 → 2. DIVU x/0 with x=0x1234 → 0xFFFFFFFF. REMU x/0 → 0x1234.
- Back-pressure: hold `out_ready`=0 for 10 cycles after a DIVU completes → result stable and `in_ready`=0; a new `in_valid` is not accepted until one cycle after `out_ready`.
- Reset mid-operation: assert `rst` 10 cycles into a MUL → next cycle IDLE with `out_valid`=0; then ADD 2+3 → 5 with latency 1.
